mem_access_stage: RTL

MEM stage of the 5-stage pipeline: takes the EX/MEM latch outputs, performs loads/stores against an internal data memory with a fixed multi-cycle access latency, and presents read data, ALU result, destination register and WB control to the MEM/WB latch. While a memory access is in flight it stalls the upstream stages and sends bubbles downstream.

---
 rtl/mem_access_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle loads/stores against an internal word memory, with stall/bubble control.
// Optional define MEM_SUBWORD_EN enables half/byte accesses (lane select, sign/zero extend, read-modify-write).
module mem_access_stage #(
  parameter int B      = 32,
  parameter int W      = 5,
  parameter int ADDR_W = 10,
  parameter int LAT    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] alu_result_in,
  input  logic [B-1:0] write_data_in,
  input  logic [W-1:0] mux_RegDst_in,
  input  logic         m_MemRead_in,
  input  logic         m_MemWrite_in,
  input  logic [1:0]   m_size_in,
  input  logic         m_unsigned_in,
  input  logic         wb_RegWrite_in,
  input  logic         wb_MemtoReg_in,
  output logic [B-1:0] read_data_out,
  output logic [B-1:0] alu_result_out,
  output logic [W-1:0] mux_RegDst_out,
  output logic         wb_RegWrite_out,
  output logic         wb_MemtoReg_out,
  output logic         stall_out,
  output logic         misaligned_out
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [B-1:0]       rdata_q, rdata_d;
  logic [B-1:0]       mem_q [DEPTH];

  logic               mem_op_s;
  logic               is_store_s;
  logic               is_load_s;
  logic               mem_we_s;
  logic [ADDR_W-1:0]  word_idx_s;
  logic               misaligned_s;
  logic [B-1:0]       load_val_s;
  logic [B-1:0]       store_word_s;

  logic               stall_s;
  logic               regwrite_s;
  logic               mis_flag_s;
  logic [B-1:0]       rdout_s;

  assign mem_op_s   = m_MemRead_in | m_MemWrite_in;
  assign is_store_s = m_MemWrite_in;
  assign is_load_s  = m_MemRead_in & ~m_MemWrite_in;
  assign word_idx_s = alu_result_in[ADDR_W+1:2];

`ifdef MEM_SUBWORD_EN
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction from the latched word, and alignment rule per access size.
  always_comb begin
    byte_s       = rdata_q[{alu_result_in[1:0], 3'b000} +: 8];
    half_s       = alu_result_in[1] ? rdata_q[31:16] : rdata_q[15:0];
    misaligned_s = 1'b0;
    load_val_s   = rdata_q;
    case (m_size_in)
      2'b01: begin
        misaligned_s = alu_result_in[0];
        load_val_s   = m_unsigned_in ? {{(B-16){1'b0}}, half_s}
                                     : {{(B-16){half_s[15]}}, half_s};
      end
      2'b10: begin
        misaligned_s = 1'b0;
        load_val_s   = m_unsigned_in ? {{(B-8){1'b0}}, byte_s}
                                     : {{(B-8){byte_s[7]}}, byte_s};
      end
      default: begin
        misaligned_s = (alu_result_in[1:0] != 2'b00);
        load_val_s   = rdata_q;
      end
    endcase
  end

  // Sub-word stores merge the new lane into the word read during WAIT.
  always_comb begin
    store_word_s = rdata_q;
    case (m_size_in)
      2'b01: begin
        if (alu_result_in[1]) begin
          store_word_s[31:16] = write_data_in[15:0];
        end else begin
          store_word_s[15:0] = write_data_in[15:0];
        end
      end
      2'b10: begin
        store_word_s[{alu_result_in[1:0], 3'b000} +: 8] = write_data_in[7:0];
      end
      default: begin
        store_word_s = write_data_in;
      end
    endcase
  end
`else
  logic unused_s;

  assign unused_s     = ^{m_size_in, m_unsigned_in};
  assign misaligned_s = (alu_result_in[1:0] != 2'b00);
  assign load_val_s   = rdata_q;
  assign store_word_s = write_data_in;
`endif

  // Access sequencer: next state, wait counter, read latch and stage control.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    stall_s    = 1'b0;
    regwrite_s = wb_RegWrite_in;
    mis_flag_s = 1'b0;
    rdout_s    = {B{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          regwrite_s = 1'b0;
          if (misaligned_s) begin
            mis_flag_s = 1'b1;
          end else begin
            stall_s = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        stall_s    = 1'b1;
        regwrite_s = 1'b0;
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rdata_d = mem_q[word_idx_s];
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rdout_s = is_load_s ? load_val_s : {B{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        regwrite_s = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  // State, counter and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= {B{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_we_s = reset & (state_q == S_DONE) & is_store_s;

  // Store commits on the DONE->IDLE edge; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_idx_s] <= store_word_s;
    end
  end

  assign read_data_out   = reset ? rdout_s        : {B{1'b0}};
  assign alu_result_out  = reset ? alu_result_in  : {B{1'b0}};
  assign mux_RegDst_out  = reset ? mux_RegDst_in  : {W{1'b0}};
  assign wb_RegWrite_out = reset & regwrite_s;
  assign wb_MemtoReg_out = reset & wb_MemtoReg_in;
  assign stall_out       = reset & stall_s;
  assign misaligned_out  = reset & mis_flag_s;

endmodule
